// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and the system address map used by
// the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_STR = 1'b1
  } arb_owner_t;

  // System address map (word addresses)
  localparam int unsigned RAM_BASE_ADDR = 120000;
  localparam int unsigned RAM_LAST_ADDR = 240999;
  localparam int unsigned SW_BASE_ADDR  = 241000;
  localparam int unsigned GPIO_ADDR     = 241021;

  // Width of the streamer RAM offset
  localparam int unsigned STR_ADDR_W = 17;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of CPU grants given while the frame
// streamer was waiting. win_o tells the arbiter the streamer must go next.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic win_o
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has precedence; increments stop at STARVE_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(STARVE_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign win_o = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single MemoryController port between the CPU
// load/store unit (priority) and the read-only frame streamer. One access is
// outstanding at a time: IDLE arbitrates, ACCESS holds the address for
// MEM_LAT+1 cycles and captures read data on the last one.
// Build option: define ARB_FAIR_EN to add the streamer anti-starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned RAM_BASE   = RAM_BASE_ADDR,
  parameter int unsigned RAM_WORDS  = RAM_LAST_ADDR - RAM_BASE_ADDR + 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_vf,
  input  logic [DATA_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wd,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rd,
  input  logic                  str_req,
  input  logic [STR_ADDR_W-1:0] str_addr,
  output logic                  str_gnt,
  output logic                  str_rvalid,
  output logic                  str_err,
  output logic [DATA_W-1:0]     str_rd,
  output logic                  mem_we,
  output logic                  mem_vf,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd,
  output logic                  busy
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              vf_q, vf_d;
  logic              err_pend_q, err_pend_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              str_gnt_q, str_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              str_rvalid_q, str_rvalid_d;
  logic              str_err_q, str_err_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] str_rd_q, str_rd_d;

  logic              arbitrate;
  logic              cpu_sel;
  logic              str_sel;
  logic              str_oob;
  logic [DATA_W-1:0] str_mem_addr;

  // An out-of-range streamer grant leaves the FSM in IDLE for one cycle while
  // its error completion is pending; arbitration is held off during that cycle
  // so the still-asserted str_req is not granted twice.
  assign arbitrate    = (state_q == IDLE) && !err_pend_q;
  assign str_oob      = (32'(str_addr) >= RAM_WORDS);
  assign str_mem_addr = DATA_W'(RAM_BASE) + DATA_W'(str_addr);

`ifdef ARB_FAIR_EN
  logic starve_win;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (arbitrate && cpu_sel && str_req),
    .clr_i ((arbitrate && str_sel) || ((state_q == IDLE) && !str_req)),
    .win_o (starve_win)
  );

  assign cpu_sel = cpu_req && !(starve_win && str_req);
`else
  assign cpu_sel = cpu_req;
`endif

  assign str_sel = str_req && !cpu_sel;

  // Next-state, latching of the winning request and completion pulses.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    we_d         = we_q;
    vf_d         = vf_q;
    err_pend_d   = 1'b0;
    cpu_gnt_d    = 1'b0;
    str_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    str_rvalid_d = 1'b0;
    str_err_d    = 1'b0;
    cpu_rd_d     = cpu_rd_q;
    str_rd_d     = str_rd_q;

    case (state_q)
      IDLE: begin
        if (err_pend_q) begin
          str_rvalid_d = 1'b1;
          str_err_d    = 1'b1;
          str_rd_d     = '0;
        end else if (cpu_sel) begin
          state_d   = ACCESS;
          owner_d   = OWN_CPU;
          lat_cnt_d = '0;
          addr_d    = cpu_addr;
          wd_d      = cpu_wd;
          we_d      = cpu_we;
          vf_d      = cpu_vf;
          cpu_gnt_d = 1'b1;
        end else if (str_sel) begin
          str_gnt_d = 1'b1;
          if (str_oob) begin
            err_pend_d = 1'b1;
          end else begin
            state_d   = ACCESS;
            owner_d   = OWN_STR;
            lat_cnt_d = '0;
            addr_d    = str_mem_addr;
            wd_d      = '0;
            we_d      = 1'b0;
            vf_d      = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (lat_cnt_q == LAT_W'(MEM_LAT)) begin
          state_d   = IDLE;
          lat_cnt_d = '0;
          if (owner_q == OWN_CPU) begin
            cpu_rd_d     = mem_rd;
            cpu_rvalid_d = 1'b1;
          end else begin
            str_rd_d     = mem_rd;
            str_rvalid_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      lat_cnt_q    <= '0;
      addr_q       <= '0;
      wd_q         <= '0;
      we_q         <= 1'b0;
      vf_q         <= 1'b0;
      err_pend_q   <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      str_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      str_rvalid_q <= 1'b0;
      str_err_q    <= 1'b0;
      cpu_rd_q     <= '0;
      str_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      we_q         <= we_d;
      vf_q         <= vf_d;
      err_pend_q   <= err_pend_d;
      cpu_gnt_q    <= cpu_gnt_d;
      str_gnt_q    <= str_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      str_rvalid_q <= str_rvalid_d;
      str_err_q    <= str_err_d;
      cpu_rd_q     <= cpu_rd_d;
      str_rd_q     <= str_rd_d;
    end
  end

  assign busy       = (state_q == ACCESS);
  assign mem_addr   = busy ? addr_q : '0;
  assign mem_wd     = busy ? wd_q : '0;
  assign mem_vf     = busy && vf_q;
  assign mem_we     = busy && we_q && (lat_cnt_q == '0);
  assign cpu_gnt    = cpu_gnt_q;
  assign str_gnt    = str_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign str_rvalid = str_rvalid_q;
  assign str_err    = str_err_q;
  assign cpu_rd     = cpu_rd_q;
  assign str_rd     = str_rd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned DATA_W     = 128;
  localparam int unsigned MEM_LAT    = 1;
  localparam int unsigned RAM_BASE   = RAM_BASE_ADDR;
  localparam int unsigned RAM_WORDS  = RAM_LAST_ADDR - RAM_BASE_ADDR + 1;
  localparam int unsigned STARVE_MAX = 8;
  localparam int          WIN        = 12;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              cpu_req, cpu_we, cpu_vf;
  logic [DATA_W-1:0] cpu_addr, cpu_wd;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rd;
  logic              str_req;
  logic [16:0]       str_addr;
  logic              str_gnt, str_rvalid, str_err;
  logic [DATA_W-1:0] str_rd;
  logic              mem_we, mem_vf;
  logic [DATA_W-1:0] mem_addr, mem_wd;
  logic [DATA_W-1:0] mem_rd = '0;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  // Expected per-cycle behaviour of one scenario window
  bit                exp_cg[WIN], exp_cv[WIN], exp_sg[WIN], exp_sv[WIN], exp_se[WIN];
  bit                exp_we[WIN], exp_busy[WIN], exp_vf[WIN], chk_cpu[WIN];
  logic [DATA_W-1:0] exp_addr[WIN], exp_wd[WIN], exp_crd[WIN], exp_srd[WIN];

  mem_port_arbiter #(
    .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .RAM_BASE(RAM_BASE),
    .RAM_WORDS(RAM_WORDS), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_vf(cpu_vf),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
    .str_req(str_req), .str_addr(str_addr),
    .str_gnt(str_gnt), .str_rvalid(str_rvalid), .str_err(str_err), .str_rd(str_rd),
    .mem_we(mem_we), .mem_vf(mem_vf), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: data = address + 5, one cycle after the address
  always @(posedge clk) mem_rd <= mem_addr + DATA_W'(5);

  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < WIN; i++) begin
      exp_cg[i] = 0; exp_cv[i] = 0; exp_sg[i] = 0; exp_sv[i] = 0; exp_se[i] = 0;
      exp_we[i] = 0; exp_busy[i] = 0; exp_vf[i] = 0; chk_cpu[i] = 0;
      exp_addr[i] = '0; exp_wd[i] = '0; exp_crd[i] = '0; exp_srd[i] = '0;
    end
  endtask

  // CPU transaction granted in cycle g; returns the earliest next grant cycle
  task automatic add_cpu(input int g, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input bit we, input bit vf, output int nxt);
    exp_cg[g] = 1;
    exp_we[g] = we;
    for (int k = 0; k <= MEM_LAT; k++) begin
      exp_busy[g+k] = 1; exp_addr[g+k] = a; exp_wd[g+k] = wd;
      exp_vf[g+k] = vf; chk_cpu[g+k] = 1;
    end
    exp_cv[g+MEM_LAT+1]  = 1;
    exp_crd[g+MEM_LAT+1] = a + DATA_W'(5);
    nxt = g + MEM_LAT + 2;
  endtask

  // Streamer transaction granted in cycle g
  task automatic add_str(input int g, input logic [16:0] off, output int nxt);
    exp_sg[g] = 1;
    if (32'(off) >= RAM_WORDS) begin
      exp_sv[g+1] = 1; exp_se[g+1] = 1; exp_srd[g+1] = '0;
      nxt = g + 2;
    end else begin
      for (int k = 0; k <= MEM_LAT; k++) begin
        exp_busy[g+k] = 1; exp_addr[g+k] = DATA_W'(RAM_BASE) + DATA_W'(off);
      end
      exp_sv[g+MEM_LAT+1]  = 1;
      exp_srd[g+MEM_LAT+1] = DATA_W'(RAM_BASE) + DATA_W'(off) + DATA_W'(5);
      nxt = g + MEM_LAT + 2;
    end
  endtask

  // One scenario from idle: optional CPU request (at cycle 0, or raised in
  // cycle 1 when late) and optional streamer request at cycle 0.
  task automatic run_scn(input string nm, input bit use_cpu, input bit cpu_late, input bit use_str,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input bit we, input bit vf, input logic [16:0] off);
    int t;
    t = 1;
    clear_exp();
    if (use_cpu && !cpu_late) begin
      add_cpu(t, a, wd, we, vf, t);
      if (use_str) add_str(t, off, t);
    end else begin
      if (use_str) add_str(t, off, t);
      if (use_cpu) begin
        if (t < 2) t = 2;
        add_cpu(t, a, wd, we, vf, t);
      end
    end
    @(posedge clk); #1;
    cpu_addr = a; cpu_wd = wd; cpu_we = we; cpu_vf = vf; str_addr = off;
    cpu_req = use_cpu && !cpu_late;
    str_req = use_str;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      check_val($sformatf("%s c%0d cpu_gnt", nm, c), DATA_W'(cpu_gnt), DATA_W'(exp_cg[c]));
      check_val($sformatf("%s c%0d cpu_rvalid", nm, c), DATA_W'(cpu_rvalid), DATA_W'(exp_cv[c]));
      check_val($sformatf("%s c%0d str_gnt", nm, c), DATA_W'(str_gnt), DATA_W'(exp_sg[c]));
      check_val($sformatf("%s c%0d str_rvalid", nm, c), DATA_W'(str_rvalid), DATA_W'(exp_sv[c]));
      check_val($sformatf("%s c%0d str_err", nm, c), DATA_W'(str_err), DATA_W'(exp_se[c]));
      check_val($sformatf("%s c%0d mem_we", nm, c), DATA_W'(mem_we), DATA_W'(exp_we[c]));
      check_val($sformatf("%s c%0d busy", nm, c), DATA_W'(busy), DATA_W'(exp_busy[c]));
      check_val($sformatf("%s c%0d mem_addr", nm, c), mem_addr, exp_addr[c]);
      if (chk_cpu[c]) begin
        check_val($sformatf("%s c%0d mem_wd", nm, c), mem_wd, exp_wd[c]);
        check_val($sformatf("%s c%0d mem_vf", nm, c), DATA_W'(mem_vf), DATA_W'(exp_vf[c]));
      end
      if (exp_cv[c]) check_val($sformatf("%s c%0d cpu_rd", nm, c), cpu_rd, exp_crd[c]);
      if (exp_sv[c]) check_val($sformatf("%s c%0d str_rd", nm, c), str_rd, exp_srd[c]);
      if (cpu_gnt) cpu_req = 1'b0;
      if (str_gnt) str_req = 1'b0;
      if (cpu_late && use_cpu && c == 1) cpu_req = 1'b1;
    end
  endtask

  task automatic check_quiet(input string nm);
    check_val({nm, " busy"}, DATA_W'(busy), '0);
    check_val({nm, " mem_addr"}, mem_addr, '0);
    check_val({nm, " mem_we"}, DATA_W'(mem_we), '0);
    check_val({nm, " cpu_gnt"}, DATA_W'(cpu_gnt), '0);
    check_val({nm, " cpu_rvalid"}, DATA_W'(cpu_rvalid), '0);
    check_val({nm, " str_rvalid"}, DATA_W'(str_rvalid), '0);
    check_val({nm, " cpu_rd"}, cpu_rd, '0);
  endtask

  initial begin
    logic [DATA_W-1:0] ra, rw;
    logic [16:0]       off;
    bit                seq[$];
    int                sc;

    rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_vf = 0; cpu_addr = '0; cpu_wd = '0;
    str_req = 0; str_addr = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed transactions
    run_scn("cpu_rd_ram", 1, 0, 0, DATA_W'(RAM_BASE_ADDR), '0, 0, 1, '0);
    run_scn("cpu_wr_gpio", 1, 0, 0, DATA_W'(GPIO_ADDR), DATA_W'(8'hAB), 1, 0, '0);
    run_scn("str_off10", 0, 0, 1, '0, '0, 0, 0, 17'd10);
    run_scn("str_oob", 0, 0, 1, '0, '0, 0, 0, 17'(RAM_WORDS));
    run_scn("str_last", 0, 0, 1, '0, '0, 0, 0, 17'(RAM_WORDS - 1));
    run_scn("both", 1, 0, 1, DATA_W'(SW_BASE_ADDR), DATA_W'(7), 1, 1, 17'd3);
    run_scn("str_then_cpu", 1, 1, 1, DATA_W'(55), DATA_W'(9), 0, 0, 17'd200);
    run_scn("oob_then_cpu", 1, 1, 1, DATA_W'(77), DATA_W'(1), 1, 0, 17'h1FFFF);

    // Reset in the middle of a CPU access
    @(posedge clk); #1;
    cpu_addr = DATA_W'(1234); cpu_we = 1'b1; cpu_wd = DATA_W'(42); cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("midrst busy_before", DATA_W'(busy), DATA_W'(1));
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_quiet("midrst async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val($sformatf("midrst post c%0d cpu_rvalid", c), DATA_W'(cpu_rvalid), '0);
      check_val($sformatf("midrst post c%0d busy", c), DATA_W'(busy), '0);
    end
    run_scn("after_rst", 1, 0, 0, DATA_W'(RAM_BASE_ADDR + 9), '0, 0, 0, '0);

    // Randomized scenarios
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rw = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: off = 17'($urandom_range(0, RAM_WORDS - 1));
        1: off = 17'($urandom_range(RAM_WORDS, 131071));
        2: off = 17'(RAM_WORDS - 1);
        default: off = 17'(RAM_WORDS);
      endcase
      sc = $urandom_range(0, 3);
      run_scn($sformatf("rnd%0d_s%0d", i, sc), sc != 1, sc == 3, sc != 0, ra, rw,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), off);
    end

    // Both requests held continuously: grant ordering
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    cpu_addr = DATA_W'(500); cpu_we = 1'b0; str_addr = 17'd5;
    cpu_req = 1'b1; str_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cpu_gnt) seq.push_back(1'b0);
      if (str_gnt) seq.push_back(1'b1);
    end
    cpu_req = 1'b0; str_req = 1'b0;
    check_val("hold grant_count", DATA_W'(seq.size()), DATA_W'(33));
    for (int i = 0; i < seq.size() && i < 33; i++)
      check_val($sformatf("hold grant%0d is_str", i), DATA_W'(seq[i]),
                DATA_W'(FAIR && ((i % (STARVE_MAX + 1)) == STARVE_MAX)));
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
